// File: rtl/cpu_mem_responder_if.sv
// Memory port between the RV32I multicycle core and its memory-side responder.
// master: core side (drives requests, receives rdata/resp/err/busy).
// slave: responder side (receives requests, drives rdata/resp/err/busy).
interface cpu_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_err, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_err, busy
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Fixed-latency word-addressed RAM responder for the core memory port.
// Ports: clk, rst (sync, active-high), bus (slave modport): read/write request,
// byte enables, address, wdata in; rdata, one-cycle resp/err pulses, busy out.
module cpu_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h40000000
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_mem_responder_if.slave   bus
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;

  // Request copy taken at acceptance; later input changes are ignored.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        wr_q;
  logic        conflict_q;

  logic [31:0] rdata_q;

  // Storage starts zeroed and is deliberately untouched by rst.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic                  req;
  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic                  err;
  logic                  do_write;
  logic                  unused_offset_bits;

  assign req = bus.mem_read | bus.mem_write;

  // Wrapping subtract: addresses below the base become huge offsets and
  // therefore fall out of range naturally.
  assign offset             = addr_q - BASE_ADDR;
  assign in_range           = (offset[31:DEPTH_LOG2+2] == '0);
  assign idx                = offset[DEPTH_LOG2+1:2];
  assign unused_offset_bits = ^offset[1:0];
  assign rd_word            = in_range ? mem[idx] : 32'h0;
  assign err                = !in_range || conflict_q;

  // Writes land on the edge closing the RESP cycle; a reset on that edge
  // cancels the write along with everything else in flight.
  assign do_write = (state == S_RESP) && wr_q && !err && !rst;

  // State register and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req)
        cnt <= LOAD;
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
      if (state == S_RESP)
        rdata_q <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      addr_q     <= bus.mem_address;
      wdata_q    <= bus.mem_wdata;
      be_q       <= bus.mem_byte_enable;
      // A simultaneous read+write is serviced as a read and flagged.
      wr_q       <= bus.mem_write && !bus.mem_read;
      conflict_q <= bus.mem_write && bus.mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      // Leaving when the counter is about to hit zero gives LATENCY-1 WAIT cycles.
      S_WAIT: if (cnt <= 4'd1) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_resp  = (state == S_RESP);
    bus.mem_err   = (state == S_RESP) && err;
    bus.busy      = (state != S_IDLE);
    // Live word during RESP (pre-write for writes), held copy afterwards.
    bus.mem_rdata = (state == S_RESP) ? rd_word : rdata_q;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: LATENCY=2 main instance plus
// LATENCY=1 and LATENCY=5 instances for back-to-back response spacing.
module tb_cpu_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic report_fail(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    miscompares++;
    $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $error("%s differs", tag);
  endtask

  cpu_mem_responder_if ifm ();
  cpu_mem_responder_if if1 ();
  cpu_mem_responder_if if5 ();

  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h40000000))
    dut (.clk(clk), .rst(rst), .bus(ifm));
  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(32'h40000000))
    dut_l1 (.clk(clk), .rst(rst), .bus(if1));
  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(5), .BASE_ADDR(32'h40000000))
    dut_l5 (.clk(clk), .rst(rst), .bus(if5));

  // Issue one request on the main port, hold it until mem_resp, then drop it
  // in the following (IDLE) cycle. lat counts cycles from first visibility.
  task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    @(posedge clk); #1;
    ifm.mem_read        = rd;
    ifm.mem_write       = wr;
    ifm.mem_byte_enable = be;
    ifm.mem_address     = addr;
    ifm.mem_wdata       = wd;
    lat   = -1;
    rdata = 32'hx;
    err   = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ifm.mem_resp) begin
        lat   = k;
        rdata = ifm.mem_rdata;
        err   = ifm.mem_err;
        break;
      end
    end
    @(posedge clk); #1;
    ifm.mem_read  = 1'b0;
    ifm.mem_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        saw_resp;

    ifm.mem_read = 1'b0; ifm.mem_write = 1'b0; ifm.mem_byte_enable = 4'h0;
    ifm.mem_address = 32'h0; ifm.mem_wdata = 32'h0;
    if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_byte_enable = 4'h0;
    if1.mem_address = 32'h40000010; if1.mem_wdata = 32'h0;
    if5.mem_read = 1'b0; if5.mem_write = 1'b0; if5.mem_byte_enable = 4'h0;
    if5.mem_address = 32'h40000010; if5.mem_wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (ifm.mem_resp !== 1'b0) report_fail("rst_resp", ifm.mem_resp, 1'b0);
    vectors++; if (ifm.mem_err !== 1'b0) report_fail("rst_err", ifm.mem_err, 1'b0);
    vectors++; if (ifm.busy !== 1'b0) report_fail("rst_busy", ifm.busy, 1'b0);
    vectors++; if (ifm.mem_rdata !== 32'h0) report_fail("rst_rdata", ifm.mem_rdata, 32'h0);

    // Full write then read back; write returns the pre-write word (zero)
    do_req(1'b0, 1'b1, 4'hF, 32'h40000010, 32'hDEADBEEF, rd, er, lat);
    vectors++; if (lat !== 2) report_fail("wr1_lat", lat, 2);
    vectors++; if (er !== 1'b0) report_fail("wr1_err", er, 1'b0);
    vectors++; if (rd !== 32'h0) report_fail("wr1_rdata", rd, 32'h0);
    do_req(1'b1, 1'b0, 4'h0, 32'h40000010, 32'h0, rd, er, lat);
    vectors++; if (lat !== 2) report_fail("rd1_lat", lat, 2);
    vectors++; if (er !== 1'b0) report_fail("rd1_err", er, 1'b0);
    vectors++; if (rd !== 32'hDEADBEEF) report_fail("rd1_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    vectors++; if (ifm.mem_rdata !== 32'hDEADBEEF) report_fail("rd1_hold", ifm.mem_rdata, 32'hDEADBEEF);
    vectors++; if (ifm.busy !== 1'b0) report_fail("rd1_idle_busy", ifm.busy, 1'b0);

    // Partial byte-lane write
    do_req(1'b0, 1'b1, 4'hF, 32'h40000020, 32'hAABBCCDD, rd, er, lat);
    do_req(1'b0, 1'b1, 4'b0101, 32'h40000020, 32'h11223344, rd, er, lat);
    vectors++; if (rd !== 32'hAABBCCDD) report_fail("be_prewrite", rd, 32'hAABBCCDD);
    vectors++; if (er !== 1'b0) report_fail("be_err", er, 1'b0);
    do_req(1'b0, 1'b1, 4'b0000, 32'h40000020, 32'h0, rd, er, lat);
    vectors++; if (lat !== 2) report_fail("be0_lat", lat, 2);
    vectors++; if (er !== 1'b0) report_fail("be0_err", er, 1'b0);
    do_req(1'b1, 1'b0, 4'h0, 32'h40000022, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hAA22CC44) report_fail("be_readback", rd, 32'hAA22CC44);

    // Out-of-range addresses
    do_req(1'b0, 1'b1, 4'hF, 32'h40000000, 32'h12345678, rd, er, lat);
    do_req(1'b1, 1'b0, 4'h0, 32'h3FFFFFFC, 32'h0, rd, er, lat);
    vectors++; if (lat !== 2) report_fail("oor_lo_lat", lat, 2);
    vectors++; if (er !== 1'b1) report_fail("oor_lo_err", er, 1'b1);
    vectors++; if (rd !== 32'h0) report_fail("oor_lo_rdata", rd, 32'h0);
    do_req(1'b1, 1'b0, 4'h0, 32'h40001000, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b1) report_fail("oor_hi_err", er, 1'b1);
    vectors++; if (rd !== 32'h0) report_fail("oor_hi_rdata", rd, 32'h0);
    do_req(1'b0, 1'b1, 4'hF, 32'h40001000, 32'hFFFFFFFF, rd, er, lat);
    vectors++; if (er !== 1'b1) report_fail("oor_wr_err", er, 1'b1);
    vectors++; if (rd !== 32'h0) report_fail("oor_wr_rdata", rd, 32'h0);
    do_req(1'b1, 1'b0, 4'h0, 32'h40000000, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'h12345678) report_fail("word0_intact", rd, 32'h12345678);
    vectors++; if (er !== 1'b0) report_fail("word0_err", er, 1'b0);

    // Read and write together: error, serviced as a read, no write
    do_req(1'b1, 1'b1, 4'hF, 32'h40000010, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b1) report_fail("both_err", er, 1'b1);
    vectors++; if (rd !== 32'hDEADBEEF) report_fail("both_rdata", rd, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 4'h0, 32'h40000010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hDEADBEEF) report_fail("both_nowrite", rd, 32'hDEADBEEF);

    // Reset during WAIT of a write aborts it
    @(posedge clk); #1;
    ifm.mem_write = 1'b1; ifm.mem_byte_enable = 4'hF;
    ifm.mem_address = 32'h40000010; ifm.mem_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (ifm.busy !== 1'b1) report_fail("abort_wait_busy", ifm.busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    ifm.mem_write = 1'b0;
    saw_resp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifm.mem_resp) saw_resp = 1'b1;
    end
    vectors++; if (saw_resp !== 1'b0) report_fail("abort_no_resp", saw_resp, 1'b0);
    vectors++; if (ifm.busy !== 1'b0) report_fail("abort_busy", ifm.busy, 1'b0);
    do_req(1'b1, 1'b0, 4'h0, 32'h40000010, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hDEADBEEF) report_fail("abort_old_val", rd, 32'hDEADBEEF);

    // Continuous reads: LATENCY=1 gives a 2-cycle period, LATENCY=5 a 6-cycle
    // period; busy drops only in the IDLE cycle of each round.
    @(posedge clk); #1;
    if1.mem_read = 1'b1;
    if5.mem_read = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      vectors++; if (if1.mem_resp !== ((k % 2) == 1)) report_fail("l1_resp", if1.mem_resp, ((k % 2) == 1));
      vectors++; if (if1.busy !== ((k % 2) != 0)) report_fail("l1_busy", if1.busy, ((k % 2) != 0));
      vectors++; if (if5.mem_resp !== ((k % 6) == 5)) report_fail("l5_resp", if5.mem_resp, ((k % 6) == 5));
      vectors++; if (if5.busy !== ((k % 6) != 0)) report_fail("l5_busy", if5.busy, ((k % 6) != 0));
    end
    @(posedge clk); #1;
    if1.mem_read = 1'b0;
    if5.mem_read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the RV32I multicycle core's memory port. It accepts the core's mem_read/mem_write requests, models a fixed-latency word-addressed RAM with byte-enabled writes, and returns mem_rdata together with a one-cycle mem_resp pulse. It serves as the synthesizable backing memory for core-level simulation and as the reference responder behaviour for future cache/arbiter work.

Parameters:
DEPTH_LOG2, 10, log2 of number of 32-bit words stored (default 1024 words = 4 KiB)
LATENCY, 2, cycles from request acceptance to mem_resp; legal range 1..15
BASE_ADDR, 32'h40000000, byte address mapped to word 0

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
mem_read  input  1  read request; held by the core until mem_resp
mem_write  input  1  write request; held by the core until mem_resp
mem_byte_enable  input  4  write byte lanes; bit i covers mem_wdata[8i+7:8i]
mem_address  input  32  byte address; bits [1:0] ignored
mem_wdata  input  32  write data
mem_rdata  output  32  read data, valid in the mem_resp cycle
mem_resp  output  1  one-cycle completion pulse
mem_err  output  1  one-cycle error pulse, coincident with mem_resp
busy  output  1  high while a request is in flight (WAIT or RESP)

Behaviour:
- Clocking: clk is the clock. Reset rst is synchronous, active-high.
- Reset values: mem_rdata=0, mem_resp=0, mem_err=0, busy=0, FSM=IDLE, latency counter=0. rst does not clear the storage array. Array initialises to all zeros at time zero.
- FSM has three states:
  - IDLE: if (mem_read | mem_write), latch address, wdata, byte_enable and request type. Load counter=LATENCY-1. Go to WAIT, or straight to RESP if LATENCY=1. Otherwise stay in IDLE.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: assert mem_resp for exactly this cycle, then return to IDLE.
- Latency: with the request accepted on edge N, mem_resp is high in the cycle after edge N+LATENCY-1. Equivalently, a request first visible in cycle C sees mem_resp in cycle C+LATENCY.
- Back-to-back: IDLE is re-entered the cycle after RESP. A request present in that cycle is treated as a new request, because the core changes state on mem_resp. Minimum spacing between responses is LATENCY+1 cycles.
- Request stability: the latched copy is used throughout. Input changes after acceptance have no effect.
- Address decode: offset = latched_addr - BASE_ADDR, 32-bit wrapping subtract. Word index = offset[DEPTH_LOG2+1:2].
  - In range iff offset[31:DEPTH_LOG2+2]==0.
  - Addresses below BASE_ADDR wrap to large offsets and are therefore out of range.
- Read: in the RESP cycle, mem_rdata = stored word, full 32 bits regardless of byte_enable. Out of range returns 0. mem_rdata holds its value after RESP until the next response.
- Write: committed at the RESP-cycle edge. Only lanes with byte_enable[i]=1 are updated. byte_enable=0000 completes normally with no change. For write responses, mem_rdata = the pre-write word (0 if out of range).
- Errors: mem_err pulses with mem_resp, and the write is dropped, in either case:
  - out-of-range address;
  - mem_read and mem_write both high at acceptance. This is treated as a read, no write.
- Reset mid-operation: rst in WAIT or RESP aborts to IDLE. No write is committed, and mem_resp/mem_err are forced low in the following cycle. Nothing pending survives.
- busy = (state != IDLE).

Test Plan:
- Reset then write 32'hDEADBEEF, be=1111, addr 32'h40000010; then read the same address -> second mem_resp exactly 2 cycles after request, mem_rdata=32'hDEADBEEF, mem_err=0.
- Write 32'h11223344, be=0101 to 32'h40000020, previously 32'hAABBCCDD -> later read returns 32'hAA22CC44.
- LATENCY=1 and LATENCY=5 builds with continuous back-to-back reads -> mem_resp at a 2-cycle and 6-cycle period respectively. Each pulse is 1 cycle wide, and busy drops only for the IDLE cycle.
- Read 32'h3FFFFFFC and 32'h40001000 (DEPTH_LOG2=10) -> mem_resp with mem_err=1, mem_rdata=0. A write to 32'h40001000 leaves word 0 unchanged.
- mem_read=mem_write=1, addr 32'h40000010, wdata 0 -> mem_err=1, mem_rdata=stored 32'hDEADBEEF, memory unchanged.
- Assert rst for 1 cycle during WAIT of a write of 32'hCAFEF00D -> no mem_resp for that request, and a subsequent read shows the old value.
